// File: rtl/fp_align_pkg.sv
// rtl/fp_align_pkg.sv - shared widths and stage bundles for the exponent-align pipeline
package fp_align_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int ALIGN_W = MAN_W + 3;

  typedef struct packed {
    logic [EXP_W-1:0] exp_g;
    logic [EXP_W-1:0] diff;
    logic             sig;
    logic [MAN_W:0]   man_g;
    logic [MAN_W:0]   man_l;
  } s1_t;

  typedef struct packed {
    logic [EXP_W-1:0]   exp_g;
    logic [EXP_W-1:0]   diff;
    logic               sig;
    logic [MAN_W:0]     man_g;
    logic [ALIGN_W-1:0] man_aligned;
    logic               sticky;
    logic               shift_sat;
  } s2_t;

  function automatic logic hidden_bit(input logic [EXP_W-1:0] e);
    return |e;
  endfunction

endpackage

// File: rtl/exp_align_shifter.sv
// rtl/exp_align_shifter.sv - barrel right shift of {hidden,man,G,R} with sticky and saturation
module exp_align_shifter
  import fp_align_pkg::*;
#(
  parameter int SH_EXP_W = EXP_W,
  parameter int SH_MAN_W = MAN_W
) (
  input  logic [SH_MAN_W:0]   man,
  input  logic [SH_EXP_W-1:0] diff,
  output logic [SH_MAN_W+2:0] aligned,
  output logic                sticky,
  output logic                sat
);

  localparam int VW   = SH_MAN_W + 3;
  localparam int SH_W = $clog2(VW);

  logic [VW-1:0]   vec;
  logic [VW-1:0]   mask;
  logic [SH_W-1:0] shamt;

  assign vec   = {man, 2'b00};
  assign sat   = (32'(diff) >= 32'(VW));
  // shamt is only meaningful when not saturated, so truncation is safe there
  assign shamt = SH_W'(diff);
  assign mask  = ~({VW{1'b1}} << shamt);

  always_comb begin
    aligned = '0;
    sticky  = 1'b0;
    if (sat) begin
      aligned = '0;
      sticky  = |vec;
    end else begin
      aligned = vec >> shamt;
      sticky  = |(vec & mask);
    end
  end

endmodule

// File: rtl/exp_align_pipe.sv
// rtl/exp_align_pipe.sv - two-stage exponent compare/swap and mantissa align with valid/ready
// Optional: EXP_ALIGN_SUBNORM_EN treats a zero exponent field as effective exponent 1.
module exp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int SIZE_EXP = EXP_W,
  parameter int SIZE_MAN = MAN_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_EXP-1:0] i_exp_a,
  input  logic [SIZE_EXP-1:0] i_exp_b,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_EXP-1:0] o_exp_greater,
  output logic [SIZE_EXP-1:0] o_diff_value,
  output logic                o_diff_signal,
  output logic [SIZE_MAN:0]   o_man_greater,
  output logic [SIZE_MAN+2:0] o_man_aligned,
  output logic                o_sticky,
  output logic                o_shift_sat
);

  s1_t s1_q, s1_next;
  s2_t s2_q, s2_next;
  logic s1_v, s2_v;
  logic s1_ready, s2_ready;

  logic [SIZE_EXP-1:0] exp_a_eff, exp_b_eff;
  logic                hid_a, hid_b;

  assign hid_a = hidden_bit(i_exp_a);
  assign hid_b = hidden_bit(i_exp_b);

`ifdef EXP_ALIGN_SUBNORM_EN
  // Subnormals share the scale of exponent 1; the hidden bit still follows the raw field.
  assign exp_a_eff = (i_exp_a == '0) ? SIZE_EXP'(1) : i_exp_a;
  assign exp_b_eff = (i_exp_b == '0) ? SIZE_EXP'(1) : i_exp_b;
`else
  assign exp_a_eff = i_exp_a;
  assign exp_b_eff = i_exp_b;
`endif

  always_comb begin
    s1_next     = '0;
    s1_next.sig = (exp_a_eff < exp_b_eff);
    if (s1_next.sig) begin
      s1_next.exp_g = exp_b_eff;
      s1_next.diff  = exp_b_eff - exp_a_eff;
      s1_next.man_g = {hid_b, i_man_b};
      s1_next.man_l = {hid_a, i_man_a};
    end else begin
      s1_next.exp_g = exp_a_eff;
      s1_next.diff  = exp_a_eff - exp_b_eff;
      s1_next.man_g = {hid_a, i_man_a};
      s1_next.man_l = {hid_b, i_man_b};
    end
  end

  logic [SIZE_MAN+2:0] sh_aligned;
  logic                sh_sticky;
  logic                sh_sat;

  exp_align_shifter #(
    .SH_EXP_W (SIZE_EXP),
    .SH_MAN_W (SIZE_MAN)
  ) u_shifter (
    .man     (s1_q.man_l),
    .diff    (s1_q.diff),
    .aligned (sh_aligned),
    .sticky  (sh_sticky),
    .sat     (sh_sat)
  );

  always_comb begin
    s2_next             = '0;
    s2_next.exp_g       = s1_q.exp_g;
    s2_next.diff        = s1_q.diff;
    s2_next.sig         = s1_q.sig;
    s2_next.man_g       = s1_q.man_g;
    s2_next.man_aligned = sh_aligned;
    s2_next.sticky      = sh_sticky;
    s2_next.shift_sat   = sh_sat;
  end

  // Each stage refills in the same cycle its contents leave, so full rate holds.
  assign s2_ready = !s2_v || i_ready;
  assign s1_ready = !s1_v || s2_ready;
  assign o_ready  = s1_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
      s2_v <= 1'b0;
      s2_q <= '0;
    end else begin
      if (s1_ready) begin
        s1_v <= i_valid;
        if (i_valid) s1_q <= s1_next;
      end
      if (s2_ready) begin
        s2_v <= s1_v;
        if (s1_v) s2_q <= s2_next;
      end
    end
  end

  assign o_valid       = s2_v;
  assign o_exp_greater = s2_q.exp_g;
  assign o_diff_value  = s2_q.diff;
  assign o_diff_signal = s2_q.sig;
  assign o_man_greater = s2_q.man_g;
  assign o_man_aligned = s2_q.man_aligned;
  assign o_sticky      = s2_q.sticky;
  assign o_shift_sat   = s2_q.shift_sat;

endmodule

// File: tb/tb_exp_align_pipe.sv
// tb/tb_exp_align_pipe.sv - directed-vector bench for exp_align_pipe (honours EXP_ALIGN_SUBNORM_EN)
module tb_exp_align_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_exp_a, i_exp_b;
  logic [22:0] i_man_a, i_man_b;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp_greater, o_diff_value;
  logic        o_diff_signal;
  logic [23:0] o_man_greater;
  logic [25:0] o_man_aligned;
  logic        o_sticky, o_shift_sat;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] ma;
    logic [22:0] mb;
    logic [69:0] exp;
  } vec_t;

  always #5 i_clk = ~i_clk;

  exp_align_pipe dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_exp_a       (i_exp_a),
    .i_exp_b       (i_exp_b),
    .i_man_a       (i_man_a),
    .i_man_b       (i_man_b),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_exp_greater (o_exp_greater),
    .o_diff_value  (o_diff_value),
    .o_diff_signal (o_diff_signal),
    .o_man_greater (o_man_greater),
    .o_man_aligned (o_man_aligned),
    .o_sticky      (o_sticky),
    .o_shift_sat   (o_shift_sat)
  );

  // {valid, exp_greater, diff, signal, man_greater, man_aligned, sticky, shift_sat}
  function automatic logic [69:0] obs();
    return {o_valid, o_exp_greater, o_diff_value, o_diff_signal,
            o_man_greater, o_man_aligned, o_sticky, o_shift_sat};
  endfunction

  task automatic drive(input logic [7:0] ea, input logic [7:0] eb,
                       input logic [22:0] ma, input logic [22:0] mb);
    i_valid = 1'b1;
    i_exp_a = ea;
    i_exp_b = eb;
    i_man_a = ma;
    i_man_b = mb;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    drive(8'h85, 8'h82, 23'h0, 23'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    @(negedge i_clk);
    n_vec++;
    if (obs() !== 70'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want %h", obs(), 70'h0);
    end
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", o_ready);
    end
  endtask

  task automatic test_align();
    vec_t tbl[9];
    tbl[0] = '{8'h85, 8'h82, 23'h0, 23'h0,
               {1'b1, 8'h85, 8'h03, 1'b0, 24'h800000, 26'h0400000, 1'b0, 1'b0}};
    tbl[1] = '{8'h84, 8'h80, 23'h0, 23'h000007,
               {1'b1, 8'h84, 8'h04, 1'b0, 24'h800000, 26'h0200001, 1'b1, 1'b0}};
    tbl[2] = '{8'h10, 8'h90, 23'h0, 23'h123456,
               {1'b1, 8'h90, 8'h80, 1'b1, 24'h923456, 26'h0000000, 1'b1, 1'b1}};
    tbl[3] = '{8'h40, 8'h40, 23'h7FFFFF, 23'h000001,
               {1'b1, 8'h40, 8'h00, 1'b0, 24'hFFFFFF, 26'h2000004, 1'b0, 1'b0}};
    tbl[4] = '{8'h99, 8'h80, 23'h0, 23'h400000,
               {1'b1, 8'h99, 8'h19, 1'b0, 24'h800000, 26'h0000001, 1'b1, 1'b0}};
    tbl[5] = '{8'h9A, 8'h80, 23'h0, 23'h0,
               {1'b1, 8'h9A, 8'h1A, 1'b0, 24'h800000, 26'h0000000, 1'b1, 1'b1}};
    tbl[6] = '{8'h83, 8'h80, 23'h0, 23'h000001,
               {1'b1, 8'h83, 8'h03, 1'b0, 24'h800000, 26'h0400000, 1'b1, 1'b0}};
`ifdef EXP_ALIGN_SUBNORM_EN
    tbl[7] = '{8'h00, 8'h01, 23'h000010, 23'h0,
               {1'b1, 8'h01, 8'h00, 1'b0, 24'h000010, 26'h2000000, 1'b0, 1'b0}};
    tbl[8] = '{8'h00, 8'h00, 23'h000005, 23'h000003,
               {1'b1, 8'h01, 8'h00, 1'b0, 24'h000005, 26'h000000C, 1'b0, 1'b0}};
`else
    tbl[7] = '{8'h00, 8'h01, 23'h000010, 23'h0,
               {1'b1, 8'h01, 8'h01, 1'b1, 24'h800000, 26'h0000020, 1'b0, 1'b0}};
    tbl[8] = '{8'h00, 8'h00, 23'h000005, 23'h000003,
               {1'b1, 8'h00, 8'h00, 1'b0, 24'h000005, 26'h000000C, 1'b0, 1'b0}};
`endif
    i_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge i_clk);
      drive(tbl[k].ea, tbl[k].eb, tbl[k].ma, tbl[k].mb);
      n_vec++;
      if (o_ready !== 1'b1) begin
        n_err++;
        $display("FAIL align_ready[%0d] got %b want 1", k, o_ready);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      n_vec++;
      if (obs() !== tbl[k].exp) begin
        n_err++;
        $display("FAIL align_vec[%0d] got %h want %h", k, obs(), tbl[k].exp);
      end
    end
    @(negedge i_clk);
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL align_drained got o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] base;
    logic [69:0] want;
    base = 26'h2000000;
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (c >= 2) begin
        want = {1'b1, 8'h80 + 8'(c - 2), 8'(c - 2), 1'b0,
                24'h800000 | 24'(c - 2), base >> (c - 2), 1'b0, 1'b0};
        n_vec++;
        if (obs() !== want) begin
          n_err++;
          $display("FAIL b2b_out[%0d] got %h want %h", c - 2, obs(), want);
        end
      end
      n_vec++;
      if (o_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready[%0d] got %b want 1", c, o_ready);
      end
      if (c < 6) drive(8'h80 + 8'(c), 8'h80, 23'(c), 23'h0);
      else i_valid = 1'b0;
    end
    @(negedge i_clk);
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drained got o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [69:0] w0, w1, w2;
    w0 = {1'b1, 8'h81, 8'h01, 1'b0, 24'h800000, 26'h1000000, 1'b0, 1'b0};
    w1 = {1'b1, 8'h82, 8'h02, 1'b1, 24'h800000, 26'h0800003, 1'b0, 1'b0};
    w2 = {1'b1, 8'h90, 8'h00, 1'b0, 24'h800001, 26'h2000008, 1'b0, 1'b0};
    i_ready = 1'b0;
    @(negedge i_clk);
    drive(8'h81, 8'h80, 23'h0, 23'h0);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept0 got o_ready=%b want 1", o_ready);
    end
    @(negedge i_clk);
    drive(8'h80, 8'h82, 23'h000003, 23'h0);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept1 got o_ready=%b want 1", o_ready);
    end
    @(negedge i_clk);
    drive(8'h90, 8'h90, 23'h000001, 23'h000002);
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (o_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall_ready[%0d] got %b want 0", s, o_ready);
      end
      n_vec++;
      if (obs() !== w0) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got %h want %h", s, obs(), w0);
      end
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    n_vec++;
    if (obs() !== w1) begin
      n_err++;
      $display("FAIL bp_drain1 got %h want %h", obs(), w1);
    end
    @(negedge i_clk);
    n_vec++;
    if (obs() !== w2) begin
      n_err++;
      $display("FAIL bp_drain2 got %h want %h", obs(), w2);
    end
    @(negedge i_clk);
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drained got o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    i_ready = 1'b0;
    @(negedge i_clk);
    drive(8'h85, 8'h82, 23'h0, 23'h0);
    @(negedge i_clk);
    drive(8'h84, 8'h80, 23'h0, 23'h000007);
    @(negedge i_clk);
    n_vec++;
    if ({o_valid, o_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_full got valid,ready=%b want 10", {o_valid, o_ready});
    end
    i_rst_n = 1'b0;
    drive(8'h33, 8'h11, 23'h1, 23'h2);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    n_vec++;
    if (obs() !== 70'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs got %h want %h", obs(), 70'h0);
    end
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready got %b want 1", o_ready);
    end
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      n_vec++;
      if (o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_stale[%0d] got o_valid=%b want 0", c, o_valid);
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_exp_a = '0;
    i_exp_b = '0;
    i_man_a = '0;
    i_man_b = '0;
    test_reset();
    test_align();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
